// File: rtl/if_id_pkg.sv
// Shared defines for the IF/ID pipeline register: reset/stall/enable levels,
// bus widths, the THCO-MIPS NOP encoding and the per-cycle mode type.
package if_id_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic Enable      = 1'b1;
  localparam logic Disable     = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int unsigned InstAddrBus = 16;
  localparam int unsigned InstBus     = 16;
  localparam logic [InstBus-1:0] NopInst = 16'h0800;

  localparam int unsigned PerfCntW = 16;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HOLD,
    MODE_BUBBLE
  } mode_e;

endpackage

// File: rtl/if_id_perf_cnt.sv
// Saturating event counter used for IF/ID bubble and hold statistics.
module if_id_perf_cnt
  import if_id_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  output logic [PerfCntW-1:0] cnt_o
);

  logic [PerfCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id.sv
// IF/ID pipeline register with stall hold, flush and NOP bubble insertion.
// Optional bubble/hold counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id
  import if_id_pkg::*;
#(
  parameter int unsigned     AW       = InstAddrBus,
  parameter int unsigned     DW       = InstBus,
  parameter logic [DW-1:0]   NOP_INST = NopInst
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic          if_ce,
  input  logic          if_inst_ready,
  input  logic [AW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  input  logic          if_in_delay_slot,
`ifdef IF_ID_PERF_CNT_EN
  output logic [PerfCntW-1:0] perf_bubble_cnt,
  output logic [PerfCntW-1:0] perf_hold_cnt,
`endif
  output logic          id_valid,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  output logic          id_in_delay_slot
);

  mode_e         mode;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          ds_q, ds_d;
  logic          valid_q, valid_d;

  // Mode depends only on current inputs; flush outranks every stall case.
  always_comb begin
    mode = MODE_RUN;
    if (flush)
      mode = MODE_BUBBLE;
    else if (stall[1] == Stop && stall[2] == Stop)
      mode = MODE_HOLD;
    else if (stall[1] == Stop)
      mode = MODE_BUBBLE;
    else if (if_ce == ChipDisable || !if_inst_ready)
      mode = MODE_BUBBLE;
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ds_d    = ds_q;
    valid_d = valid_q;
    case (mode)
      MODE_RUN: begin
        pc_d    = if_pc;
        inst_d  = if_inst;
        ds_d    = if_in_delay_slot;
        valid_d = Enable;
      end
      MODE_BUBBLE: begin
        pc_d    = '0;
        inst_d  = NOP_INST;
        ds_d    = 1'b0;
        valid_d = Disable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      ds_q    <= 1'b0;
      valid_q <= Disable;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ds_q    <= ds_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc            = pc_q;
  assign id_inst          = inst_q;
  assign id_in_delay_slot = ds_q;
  assign id_valid         = valid_q;

`ifdef IF_ID_PERF_CNT_EN
  if_id_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mode == MODE_BUBBLE),
    .cnt_o (perf_bubble_cnt)
  );

  if_id_perf_cnt u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mode == MODE_HOLD),
    .cnt_o (perf_hold_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id.sv
// Scoreboard bench for if_id: a driver pushes model expectations per edge,
// a monitor pops and compares after every rising edge.
module tb_if_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic        if_inst_ready;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
  logic        if_in_delay_slot;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
  logic        id_in_delay_slot;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] perf_bubble_cnt;
  logic [15:0] perf_hold_cnt;
`endif

  always #5 clk = ~clk;

  if_id dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .if_ce            (if_ce),
    .if_inst_ready    (if_inst_ready),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_in_delay_slot (if_in_delay_slot),
`ifdef IF_ID_PERF_CNT_EN
    .perf_bubble_cnt  (perf_bubble_cnt),
    .perf_hold_cnt    (perf_hold_cnt),
`endif
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_inst          (id_inst),
    .id_in_delay_slot (id_in_delay_slot)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        ds;
    logic [15:0] bub;
    logic [15:0] hold;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic model_reset();
    m.valid = 1'b0; m.pc = 16'h0000; m.inst = 16'h0800; m.ds = 1'b0;
    m.bub = 16'h0000; m.hold = 16'h0000;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic compare(input exp_t e);
    logic ok;
    ok = (id_valid === e.valid) && (id_pc === e.pc) && (id_inst === e.inst) &&
         (id_in_delay_slot === e.ds);
`ifdef IF_ID_PERF_CNT_EN
    ok = ok && (perf_bubble_cnt === e.bub) && (perf_hold_cnt === e.hold);
`endif
    n_checks++;
    if (ok) n_pass++;
    else begin
      $display("FAIL %s: got valid=%b pc=%h inst=%h ds=%b, want valid=%b pc=%h inst=%h ds=%b",
               e.name, id_valid, id_pc, id_inst, id_in_delay_slot, e.valid, e.pc, e.inst, e.ds);
`ifdef IF_ID_PERF_CNT_EN
      $display("FAIL %s perf: got bub=%h hold=%h, want bub=%h hold=%h",
               e.name, perf_bubble_cnt, perf_hold_cnt, e.bub, e.hold);
`endif
    end
  endtask

  // Drive one cycle of inputs and record what decode should see after the edge.
  task automatic step(input string name, input logic fl, input logic [5:0] st,
                      input logic ce, input logic rdy, input logic [15:0] pc,
                      input logic [15:0] inst, input logic ds);
    exp_t e;
    bit hold, bubble;
    @(negedge clk);
    flush = fl; stall = st; if_ce = ce; if_inst_ready = rdy;
    if_pc = pc; if_inst = inst; if_in_delay_slot = ds;
    hold   = !fl && st[1] && st[2];
    bubble = fl || (st[1] && !st[2]) || (!st[1] && (!ce || !rdy));
    if (bubble) begin
      m.valid = 1'b0; m.pc = 16'h0000; m.inst = 16'h0800; m.ds = 1'b0;
      m.bub = sat_inc(m.bub);
    end else if (hold) begin
      m.hold = sat_inc(m.hold);
    end else begin
      m.valid = 1'b1; m.pc = pc; m.inst = inst; m.ds = ds;
    end
    e = m;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_reset_now(input string name);
    exp_t e;
    model_reset();
    e = m;
    e.name = name;
    compare(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; if_ce = 1'b0; if_inst_ready = 1'b0;
    if_pc = '0; if_inst = '0; if_in_delay_slot = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_now("reset_values");
    @(negedge clk) rst = 1'b1;

    step("t1_load", 0, 6'b000000, 1, 1, 16'h0004, 16'h4A01, 0);
    for (int unsigned i = 0; i < 3; i++)
      step("t2_hold", 0, 6'b000110, 1, 1, 16'h0100 + 16'(i), 16'h1111 * 16'(i + 2), 1);
    step("t3_fetch_stall_bubble", 0, 6'b000010, 1, 1, 16'h0008, 16'h2222, 1);
    step("t4_load_ds", 0, 6'b000000, 1, 1, 16'h000C, 16'h3333, 1);
    step("t4_flush_over_hold", 1, 6'b000110, 1, 1, 16'h0010, 16'h5555, 1);
    step("t5_not_ready0", 0, 6'b000000, 1, 0, 16'h0014, 16'h6666, 0);
    step("t5_not_ready1", 0, 6'b000000, 1, 0, 16'h0018, 16'h7777, 0);
    step("t5_ready_nop", 0, 6'b000000, 1, 1, 16'h001C, 16'h0800, 0);
    step("ce_off_bubble", 0, 6'b000000, 0, 1, 16'h0020, 16'h8888, 1);
    step("id_only_stall_loads", 0, 6'b000100, 1, 1, 16'hFFFE, 16'hFFFF, 1);

    step("t6_load", 0, 6'b000000, 1, 1, 16'h0030, 16'hABCD, 1);
    step("t6_hold", 0, 6'b111110, 1, 1, 16'h0034, 16'h1234, 0);
    step("t6_hold", 0, 6'b000110, 1, 1, 16'h0038, 16'h4321, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_now("t6_async_reset");
    @(posedge clk);
    #1 check_reset_now("t6_reset_held_over_edge");
    @(negedge clk) rst = 1'b1;
    step("t6_first_load", 0, 6'b000000, 1, 1, 16'h0040, 16'h9A9A, 0);

    for (int unsigned i = 0; i < 400; i++) begin
      logic [5:0] st;
      st = 6'($urandom);
      step("random", ($urandom_range(0, 9) == 0), st,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
           16'($urandom), 16'($urandom), 1'($urandom));
    end

`ifdef IF_ID_PERF_CNT_EN
    for (int unsigned i = 0; i < 65540; i++)
      step("sat_bubble", 1, 6'b000000, 1, 1, 16'h0050, 16'h0001, 0);
    step("sat_hold_after_load", 0, 6'b000000, 1, 1, 16'h0054, 16'h0002, 0);
`endif

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id.md
Name: if_id

Overview:
- Pipeline register between the fetch stage (program counter plus instruction memory) and the decode stage of the 16-bit THCO-MIPS core.
- Captures the fetched PC, the instruction word and the delay-slot flag each cycle.
- Honours the global stall vector and the branch/exception flush.
- Inserts NOP bubbles when fetch is stalled but decode is not, or when instruction memory is not ready.

Parameters:
- AW, 16, instruction address width (matches InstAddrBus)
- DW, 16, instruction word width
- NOP_INST, 16'h0800, bubble encoding (THCO-MIPS NOP)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- stall  in  6  global stall vector; bit1 = IF/ID hold, bit2 = ID hold
- flush  in  1  discard the instruction held in IF/ID (exception/redirect)
- if_ce  in  1  instruction memory enable from the PC register
- if_inst_ready  in  1  instruction memory returned valid data this cycle
- if_pc  in  AW  address of the fetched instruction
- if_inst  in  DW  fetched instruction word
- if_in_delay_slot  in  1  fetched instruction is a branch delay slot
- id_valid  out  1  id_inst is a real instruction, not a bubble
- id_pc  out  AW  PC presented to decode
- id_inst  out  DW  instruction presented to decode
- id_in_delay_slot  out  1  delay-slot flag presented to decode

Behaviour:
- Reset (rst == 0, asynchronous):
  - id_pc = 0, id_inst = NOP_INST, id_in_delay_slot = 0, id_valid = 0.
  - Any pending capture is dropped.
- All other updates happen on the rising edge of clk. Latency is 1 cycle, if_* to id_*.
- Per-cycle priority, highest first:
  1. flush = 1: load a bubble (id_inst = NOP_INST, id_valid = 0, id_in_delay_slot = 0, id_pc = 0). Flush overrides stall.
  2. stall[1] = 1 and stall[2] = 0: load a bubble, so decode advances with a NOP.
  3. stall[1] = 1 and stall[2] = 1: HOLD. All id_* outputs keep their values.
  4. stall[1] = 0 and (if_ce = 0 or if_inst_ready = 0): load a bubble.
  5. Otherwise: LOAD. id_pc = if_pc, id_inst = if_inst, id_in_delay_slot = if_in_delay_slot, id_valid = 1.
- Bubble rule: a bubble never carries a delay-slot flag. id_pc of a bubble is 0.
- Modes RUN / HOLD / BUBBLE are a function of the current inputs only. There is no extra state beyond the output registers, apart from the optional feature.
- Reset mid-HOLD returns to the reset values immediately. The first LOAD occurs on the first edge with rst = 1, if_ce = 1, if_inst_ready = 1 and no stall.
- Simultaneous flush and HOLD: flush wins; the held instruction is discarded.
- No arithmetic is performed on the PC; it is passed through unmodified.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubble_cnt (16) and perf_hold_cnt (16).
  - perf_bubble_cnt increments on every edge that loads a bubble.
  - perf_hold_cnt increments on every HOLD edge.
  - Both counters saturate at 16'hFFFF rather than wrapping.
  - Both reset to 0 on rst.
  - A flush bubble counts as a bubble.
- Not defined:
  - The ports are absent and no counter logic is generated.
  - Core behaviour is identical in both builds.

Decomposition:
- Shared defines header:
  - RstEnable = 1'b0
  - Stop / NoStop
  - Enable / Disable
  - ChipEnable / ChipDisable
  - InstAddrBus, InstBus, NopInst
- Sub-module if_id_perf_cnt (saturating 16-bit counter with inc and rst), instantiated twice under IF_ID_PERF_CNT_EN.

Test Plan:
1. Reset, then if_pc = 16'h0004, if_inst = 16'h4A01, ready = 1, stall = 0 -> after one edge id_pc = 0004, id_inst = 4A01, id_valid = 1.
2. Held instruction 4A01, stall = 6'b000110 for 3 cycles while if_inst changes -> id_inst stays 4A01 and id_valid stays 1 for all 3 cycles.
3. stall = 6'b000010 -> next edge id_inst = 0800, id_valid = 0, id_in_delay_slot = 0.
4. if_in_delay_slot = 1, if_pc = 0010, then flush = 1 asserted together with stall = 6'b000110 -> bubble loaded, id_in_delay_slot = 0, id_pc = 0.
5. if_inst_ready = 0 for 2 cycles, then 1 with inst 16'h0800 -> two bubbles, then a valid load. With IF_ID_PERF_CNT_EN, perf_bubble_cnt increases by 2.
6. rst asserted mid-HOLD, asynchronously between edges -> outputs go to reset values immediately without a clock edge. With IF_ID_PERF_CNT_EN, the counters also clear; a preloaded FFFF count holds at FFFF on a further bubble.
